accum_cpu: RTL
==============

ACCUM_CPU -- requirements
Module: accum_cpu

Interface
REQ-001 SHALL have parameter DATA_W, default 16, accumulator/memory word width (min 12).
REQ-002 SHALL have parameter ADDR_W, default 16, word-address width (<= DATA_W).
REQ-003 SHALL have parameter NUM_OUT, default 2, number of 8-bit output ports (1..8).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports step  in  1  execute one instruction; run  in  1  free-run while high.
REQ-007 SHALL have ports busy, halt, trap  out  1  status.
REQ-008 SHALL have ports mem_req  out  1, mem_we  out  1, mem_addr  out  ADDR_W, mem_wdata  out  DATA_W, mem_ack  in  1, mem_rdata  in  DATA_W.
REQ-009 SHALL have port data_out  out  8*NUM_OUT  registered output ports, port k at [8k+7:8k].

Function
REQ-010 Instruction word: opcode = inst[DATA_W-1 -: 4]; mode = inst[DATA_W-5 -: 2]; imm = inst[DATA_W-7:0], sign-extended (sext) unless stated.
REQ-011 Opcodes: 0 NOP, 1 HALT, 2 LOAD, 3 STORE, 4 ADD, 5 SUB, 6 AND, 7 OR, 8 XOR, 9 NOT, A BR, B IF, C PUSH/CALL, D POP/RET, E SETDP, F OUT.
REQ-012 Operand modes: 00 immediate sext(imm); 01 mem[zero-ext imm]; 10 mem[dp+sext(imm)]; 11 mem[sp+sext(imm)]; address sums wrap mod 2^ADDR_W.
REQ-013 States: IDLE, FETCH, EXEC, MEM, HALT, TRAP; busy = FETCH|EXEC|MEM.
REQ-014 IDLE -> FETCH when step or run high; FETCH asserts mem_req, mem_we=0, mem_addr=pc.
REQ-015 Handshake: mem_req, mem_we, mem_addr, mem_wdata held stable until the cycle mem_ack=1; request drops the next cycle; mem_rdata sampled only on mem_ack.
REQ-016 FETCH -> EXEC on mem_ack, latching inst; register/immediate ops complete in EXEC and return to IDLE, pc <= pc+1.
REQ-017 Memory-operand ops go EXEC -> MEM, issue one access, complete on mem_ack -> IDLE.
REQ-018 LOAD/ADD/SUB/AND/OR/XOR/NOT/POP update accum and zero flag (accum result == 0).
REQ-019 STORE with mode 00 SHALL enter TRAP.
REQ-020 BR: pc <= pc+1+sext(imm), mode ignored, wraps.
REQ-021 IF: mode 00 skip next if zero=0; 01 skip if zero=1; 10/11 per REQ-031; skipped instruction only advances pc, no memory access, no state change.
REQ-022 PUSH (mode 00): sp <= sp-1, mem[sp-1] <= accum; CALL (mode 01): mem[sp-1] <= pc+1, sp <= sp-1, pc <= zero-ext imm.
REQ-023 POP (mode 00): accum <= mem[sp], sp <= sp+1; RET (mode 01): pc <= mem[sp], sp <= sp+1; modes 10/11 of C/D trap.
REQ-024 SETDP: dp <= accum. OUT: port = zero-ext imm; port >= NUM_OUT traps; else data_out port <= accum[7:0].
REQ-025 HALT enters HALT (unless skipped); HALT and TRAP are left only by reset.
REQ-026 sp decrement from 0 wraps to 2^ADDR_W-1 without trap.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, mem_req=0, mem_we=0, pc=sp=dp=accum=0, flags=0, skip=0, data_out=0, even mid-transaction.
REQ-028 After reset release, a pending mem_ack from the aborted access SHALL be ignored outside FETCH/MEM.

Configuration
REQ-029 Macro ACCUM_CPU_CARRY_EN SHALL compile in a carry flag.
REQ-030 With it: ADD sets carry = carry-out of DATA_W-bit sum; SUB sets carry = borrow; other ops keep carry; reset clears it.
REQ-031 With it: IF mode 10 skips if carry=0, mode 11 skips if carry=1; without it IF modes 10/11 trap and no carry register exists.

Structure
REQ-032 Opcode, mode and state encodings SHALL live in shared package accum_cpu_pkg.
REQ-033 Instruction decode SHALL be sub-module accum_cpu_decode (combinational: opcode class, operand mode, sext imm).

Verification (DATA_W=ADDR_W=16, NUM_OUT=2)
REQ-034 mem[0]=0x2005 (LOAD #5), step, mem_ack after 3 cycles -> mem_addr=0 stable, accum=5, pc=1, busy low after.
REQ-035 0x23FF, 0x4001, 0xB800 -> accum=0, zero=1; with macro carry=1, IF no skip; without macro trap=1.
REQ-036 LOAD #7, PUSH 0xC000, POP 0xD000 from sp=0 -> write 7 to 0xFFFF, sp=0xFFFF, then read 0xFFFF, sp=0.
REQ-037 LOAD #1, IF 0xB000, STORE 0x3010 -> no mem_we pulse, pc advances past STORE.
REQ-038 LOAD #0x5A, OUT 0xF001 -> data_out[15:8]=0x5A; OUT 0xF002 -> trap=1.
REQ-039 rst_n low while FETCH awaits mem_ack -> mem_req=0, busy=0 same cycle, pc=0.

Source files
------------

// File: rtl/accum_cpu_pkg.sv
// Shared encodings for the accumulator CPU: opcodes, operand modes, FSM states.
package accum_cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_HALT  = 4'h1,
    OP_LOAD  = 4'h2,
    OP_STORE = 4'h3,
    OP_ADD   = 4'h4,
    OP_SUB   = 4'h5,
    OP_AND   = 4'h6,
    OP_OR    = 4'h7,
    OP_XOR   = 4'h8,
    OP_NOT   = 4'h9,
    OP_BR    = 4'hA,
    OP_IF    = 4'hB,
    OP_PUSH  = 4'hC,
    OP_POP   = 4'hD,
    OP_SETDP = 4'hE,
    OP_OUT   = 4'hF
  } opcode_e;

  // For PUSH/POP, MD_IMM selects the data form and MD_ABS selects CALL/RET.
  typedef enum logic [1:0] {
    MD_IMM = 2'b00,
    MD_ABS = 2'b01,
    MD_DP  = 2'b10,
    MD_SP  = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4,
    ST_TRAP  = 3'd5
  } state_e;

endpackage

// File: rtl/accum_cpu_decode.sv
// Combinational instruction decode: opcode, operand mode, extended immediates,
// memory-access class and illegal-instruction detection.
// ACCUM_CPU_CARRY_EN makes IF modes 10/11 legal (carry tests).
module accum_cpu_decode
  import accum_cpu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int NUM_OUT = 2
) (
  input  logic [DATA_W-1:0] inst_i,
  output opcode_e           op_o,
  output mode_e             mode_o,
  output logic [DATA_W-1:0] imm_sext_o,
  output logic [ADDR_W-1:0] imm_aext_o,
  output logic [ADDR_W-1:0] imm_zext_o,
  output logic              mem_op_o,
  output logic              mem_we_o,
  output logic              illegal_o
);

  localparam int IMM_W = DATA_W - 6;

  logic [IMM_W-1:0] imm;
  logic             port_bad;

  assign op_o       = opcode_e'(inst_i[DATA_W-1 -: 4]);
  assign mode_o     = mode_e'(inst_i[DATA_W-5 -: 2]);
  assign imm        = inst_i[IMM_W-1:0];
  assign imm_sext_o = DATA_W'($signed(imm));
  assign imm_aext_o = ADDR_W'($signed(imm));
  assign imm_zext_o = ADDR_W'(imm);
  assign port_bad   = (imm >= IMM_W'(NUM_OUT));

  // Classify the instruction: operand access needed, write or read, or illegal.
  always_comb begin
    mem_op_o  = 1'b0;
    mem_we_o  = 1'b0;
    illegal_o = 1'b0;
    case (op_o)
      OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        mem_op_o = (mode_o != MD_IMM);
      end
      OP_STORE: begin
        if (mode_o == MD_IMM) begin
          illegal_o = 1'b1;
        end else begin
          mem_op_o = 1'b1;
          mem_we_o = 1'b1;
        end
      end
      OP_IF: begin
`ifndef ACCUM_CPU_CARRY_EN
        illegal_o = mode_o[1];
`endif
      end
      OP_PUSH: begin
        if (mode_o[1]) begin
          illegal_o = 1'b1;
        end else begin
          mem_op_o = 1'b1;
          mem_we_o = 1'b1;
        end
      end
      OP_POP: begin
        if (mode_o[1]) illegal_o = 1'b1;
        else           mem_op_o  = 1'b1;
      end
      OP_OUT: illegal_o = port_bad;
      default: ;
    endcase
  end

endmodule

// File: rtl/accum_cpu.sv
// Accumulator CPU: single-step / free-run sequencer with a req/ack memory port
// and NUM_OUT registered byte output ports.
// Optional feature macro ACCUM_CPU_CARRY_EN: carry flag set by ADD/SUB and
// tested by IF modes 10/11 (those modes trap when it is not defined).
module accum_cpu
  import accum_cpu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int NUM_OUT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 step,
  input  logic                 run,
  output logic                 busy,
  output logic                 halt,
  output logic                 trap,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic                 mem_ack,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic [8*NUM_OUT-1:0] data_out
);

  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d, sp_q, sp_d, dp_q, dp_d;
  logic [DATA_W-1:0]    accum_q, accum_d, inst_q, inst_d;
  logic                 zero_q, zero_d, skip_q, skip_d;
  logic [8*NUM_OUT-1:0] data_out_q, data_out_d;
`ifdef ACCUM_CPU_CARRY_EN
  logic                 carry_q, carry_d;
`endif

  opcode_e           op;
  mode_e             mode;
  logic [DATA_W-1:0] imm_sext;
  logic [ADDR_W-1:0] imm_aext, imm_zext;
  logic              dec_mem_op, dec_we, dec_illegal;

  logic [ADDR_W-1:0] pc_inc, sp_inc, sp_dec, ea;
  logic [DATA_W-1:0] opnd, alu_res;
  logic [DATA_W:0]   sum, diff;
  logic              if_skip, acc_wr;

  accum_cpu_decode #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_OUT(NUM_OUT)
  ) u_decode (
    .inst_i    (inst_q),
    .op_o      (op),
    .mode_o    (mode),
    .imm_sext_o(imm_sext),
    .imm_aext_o(imm_aext),
    .imm_zext_o(imm_zext),
    .mem_op_o  (dec_mem_op),
    .mem_we_o  (dec_we),
    .illegal_o (dec_illegal)
  );

  assign pc_inc = pc_q + ONE_A;
  assign sp_inc = sp_q + ONE_A;
  assign sp_dec = sp_q - ONE_A;

  // Operand/stack effective address; stack ops ignore the addressing mode.
  always_comb begin
    case (mode)
      MD_DP:   ea = dp_q + imm_aext;
      MD_SP:   ea = sp_q + imm_aext;
      default: ea = imm_zext;
    endcase
    if (op == OP_PUSH)     ea = sp_dec;
    else if (op == OP_POP) ea = sp_q;
  end

  // ALU: operand comes from the immediate in EXEC and from memory in MEM.
  always_comb begin
    opnd = (state_q == ST_MEM) ? mem_rdata : imm_sext;
    sum  = {1'b0, accum_q} + {1'b0, opnd};
    diff = {1'b0, accum_q} - {1'b0, opnd};
    case (op)
      OP_ADD:  alu_res = sum[DATA_W-1:0];
      OP_SUB:  alu_res = diff[DATA_W-1:0];
      OP_AND:  alu_res = accum_q & opnd;
      OP_OR:   alu_res = accum_q | opnd;
      OP_XOR:  alu_res = accum_q ^ opnd;
      OP_NOT:  alu_res = ~accum_q;
      default: alu_res = opnd;
    endcase
  end

  // IF condition: true means the next instruction is skipped.
  always_comb begin
    if_skip = 1'b0;
    case (mode)
      MD_IMM: if_skip = ~zero_q;
      MD_ABS: if_skip = zero_q;
`ifdef ACCUM_CPU_CARRY_EN
      MD_DP:  if_skip = ~carry_q;
      MD_SP:  if_skip = carry_q;
`endif
      default: ;
    endcase
  end

  // Memory port is a pure function of state so reset drops it immediately.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    mem_wdata = '0;
    if (state_q == ST_FETCH) begin
      mem_req = 1'b1;
    end else if (state_q == ST_MEM) begin
      mem_req   = 1'b1;
      mem_we    = dec_we;
      mem_addr  = ea;
      mem_wdata = (op == OP_PUSH && mode == MD_ABS) ? DATA_W'(pc_inc) : accum_q;
    end
  end

  // Next-state and architectural register updates.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    sp_d       = sp_q;
    dp_d       = dp_q;
    accum_d    = accum_q;
    zero_d     = zero_q;
    skip_d     = skip_q;
    inst_d     = inst_q;
    data_out_d = data_out_q;
    acc_wr     = 1'b0;
`ifdef ACCUM_CPU_CARRY_EN
    carry_d    = carry_q;
`endif
    case (state_q)
      ST_IDLE: if (step || run) state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ack) begin
          inst_d  = mem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (skip_q) begin
          skip_d  = 1'b0;
          pc_d    = pc_inc;
          state_d = ST_IDLE;
        end else if (dec_illegal) begin
          state_d = ST_TRAP;
        end else if (op == OP_HALT) begin
          state_d = ST_HALT;
        end else if (dec_mem_op) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_IDLE;
          pc_d    = pc_inc;
          case (op)
            OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: acc_wr = 1'b1;
            OP_BR:    pc_d   = pc_inc + imm_aext;
            OP_IF:    skip_d = if_skip;
            OP_SETDP: dp_d   = ADDR_W'(accum_q);
            OP_OUT: begin
              for (int k = 0; k < NUM_OUT; k++) begin
                if (imm_zext == ADDR_W'(k)) data_out_d[8*k +: 8] = accum_q[7:0];
              end
            end
            default: ;
          endcase
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          state_d = ST_IDLE;
          pc_d    = pc_inc;
          case (op)
            OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: acc_wr = 1'b1;
            OP_PUSH: begin
              sp_d = sp_dec;
              if (mode == MD_ABS) pc_d = imm_zext;
            end
            OP_POP: begin
              sp_d = sp_inc;
              if (mode == MD_ABS) pc_d   = mem_rdata[ADDR_W-1:0];
              else                acc_wr = 1'b1;
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
    if (acc_wr) begin
      accum_d = alu_res;
      zero_d  = (alu_res == '0);
`ifdef ACCUM_CPU_CARRY_EN
      if (op == OP_ADD)      carry_d = sum[DATA_W];
      else if (op == OP_SUB) carry_d = diff[DATA_W];
`endif
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      sp_q       <= '0;
      dp_q       <= '0;
      accum_q    <= '0;
      zero_q     <= 1'b0;
      skip_q     <= 1'b0;
      inst_q     <= '0;
      data_out_q <= '0;
`ifdef ACCUM_CPU_CARRY_EN
      carry_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      sp_q       <= sp_d;
      dp_q       <= dp_d;
      accum_q    <= accum_d;
      zero_q     <= zero_d;
      skip_q     <= skip_d;
      inst_q     <= inst_d;
      data_out_q <= data_out_d;
`ifdef ACCUM_CPU_CARRY_EN
      carry_q    <= carry_d;
`endif
    end
  end

  assign busy     = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_MEM);
  assign halt     = (state_q == ST_HALT);
  assign trap     = (state_q == ST_TRAP);
  assign data_out = data_out_q;

endmodule
